dmac_master_burst: RTL and testbench

Parametrised DMA bus master: successor to the single-word DMAC master. Pops transfer descriptors (source address, destination address, word count) from the descriptor FIFO. Moves each block word-by-word over the shared bus: read from source, then write to destination, with auto-incrementing addresses. Sits between the descriptor FIFO and the bus arbiter; m_begin comes from the DMAC slave/control register block, and m_end returns to it.

---
 rtl/dmac_pkg.sv | 22 ++
 rtl/dmac_addr_gen.sv | 46 ++++
 rtl/dmac_master_burst.sv | 127 ++++++++++++
 tb/tb_dmac_master_burst.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared DMAC definitions: state codes and default widths for the master, slave and FIFO.
package dmac_pkg;

  localparam int DMAC_DATA_W    = 32;
  localparam int DMAC_ADDR_W    = 16;
  localparam int DMAC_LEN_W     = 8;
  localparam int DMAC_ADDR_STEP = 1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_POP       = 4'd1;
  localparam logic [3:0] ST_WAIT_DESC = 4'd2;
  localparam logic [3:0] ST_RD_REQ    = 4'd3;
  localparam logic [3:0] ST_RD_CAP    = 4'd4;
  localparam logic [3:0] ST_WR_REQ    = 4'd5;
  localparam logic [3:0] ST_NEXT      = 4'd6;
  localparam logic [3:0] ST_DONE      = 4'd7;

  function automatic logic is_bus_state(input logic [3:0] s);
    return (s == ST_RD_REQ) || (s == ST_WR_REQ);
  endfunction

endpackage

// File: rtl/dmac_addr_gen.sv
// Source/destination pointers and remaining word count for the burst DMAC master.
module dmac_addr_gen
  import dmac_pkg::*;
#(
  parameter int ADDR_W    = DMAC_ADDR_W,
  parameter int LEN_W     = DMAC_LEN_W,
  parameter int ADDR_STEP = DMAC_ADDR_STEP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_src,
  input  logic [ADDR_W-1:0] load_dst,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [ADDR_W-1:0] src_next,
  output logic              last_word
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [LEN_W-1:0] cnt;

  // Pointer sums are truncated to ADDR_W so addresses wrap silently.
  assign src_next  = src_ptr + STEP;
  assign last_word = (cnt == LEN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
    end else if (load) begin
      src_ptr <= load_src;
      dst_ptr <= load_dst;
      cnt     <= load_len;
    end else if (step) begin
      src_ptr <= src_next;
      dst_ptr <= dst_ptr + STEP;
      cnt     <= cnt - LEN_W'(1);
    end
  end

endmodule

// File: rtl/dmac_master_burst.sv
// Burst DMA bus master: pops descriptors and copies each block word by word (read then write).
// Optional descriptor-abort reporting is enabled with the DMAC_MASTER_ERR_EN macro.
module dmac_master_burst
  import dmac_pkg::*;
#(
  parameter int DATA_W    = DMAC_DATA_W,
  parameter int ADDR_W    = DMAC_ADDR_W,
  parameter int LEN_W     = DMAC_LEN_W,
  parameter int ADDR_STEP = DMAC_ADDR_STEP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m_begin,
  input  logic              desc_empty,
  output logic              desc_pop,
  input  logic              desc_ack,
  input  logic              desc_err,
  input  logic [ADDR_W-1:0] desc_src,
  input  logic [ADDR_W-1:0] desc_dst,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              m_req,
  output logic              m_wr,
  input  logic              m_grant,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic              m_end,
  output logic              m_err,
  output logic              busy,
  output logic [3:0]        state
);

  logic [3:0]        state_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [ADDR_W-1:0] src_next;
  logic              last_word;
  logic              err_take;
  logic              load;
  logic              step;

`ifdef DMAC_MASTER_ERR_EN
  assign err_take = (state == ST_WAIT_DESC) && desc_err;
`else
  logic unused_desc_err;
  assign unused_desc_err = desc_err;
  assign err_take        = 1'b0;
`endif

  assign load = (state == ST_WAIT_DESC) && desc_ack && !err_take;
  assign step = (state == ST_WR_REQ) && m_grant;

  dmac_addr_gen #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .ADDR_STEP (ADDR_STEP)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .load_src  (desc_src),
    .load_dst  (desc_dst),
    .load_len  (desc_len),
    .src_ptr   (src_ptr),
    .dst_ptr   (dst_ptr),
    .src_next  (src_next),
    .last_word (last_word)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:      if (m_begin) state_d = desc_empty ? ST_DONE : ST_POP;
      ST_POP:       state_d = ST_WAIT_DESC;
      ST_WAIT_DESC: begin
        if (err_take)      state_d = ST_NEXT;
        else if (desc_ack) state_d = (desc_len == '0) ? ST_NEXT : ST_RD_REQ;
      end
      ST_RD_REQ:    if (m_grant) state_d = ST_RD_CAP;
      ST_RD_CAP:    state_d = ST_WR_REQ;
      ST_WR_REQ:    if (m_grant) state_d = last_word ? ST_NEXT : ST_RD_REQ;
      ST_NEXT:      state_d = desc_empty ? ST_DONE : ST_POP;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Every output is a flop loaded from the next state, so bus signals only move on clock edges.
  // The address mux picks the pointer value that will be current once this edge has landed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      desc_pop  <= 1'b0;
      m_end     <= 1'b0;
      m_err     <= 1'b0;
      m_req     <= 1'b0;
      m_wr      <= 1'b0;
      m_address <= '0;
      m_dout    <= '0;
      data_q    <= '0;
    end else begin
      state    <= state_d;
      busy     <= (state_d != ST_IDLE);
      desc_pop <= (state_d == ST_POP);
      m_end    <= (state_d == ST_DONE);
      m_err    <= err_take;
      m_req    <= is_bus_state(state_d);
      m_wr     <= (state_d == ST_WR_REQ);
      if (state == ST_RD_CAP) data_q <= m_din;
      case (state_d)
        ST_RD_REQ: begin
          if (state == ST_WAIT_DESC)   m_address <= desc_src;
          else if (state == ST_WR_REQ) m_address <= src_next;
          else                         m_address <= src_ptr;
        end
        ST_WR_REQ: m_address <= dst_ptr;
        default:   m_address <= '0;
      endcase
      if (state_d == ST_WR_REQ) m_dout <= (state == ST_RD_CAP) ? m_din : data_q;
      else                      m_dout <= '0;
    end
  end

endmodule

// File: tb/tb_dmac_master_burst.sv
// Self-checking bench for dmac_master_burst: FIFO and bus models feed a read/write scoreboard.
// The descriptor-abort step is only built when DMAC_MASTER_ERR_EN is defined.
module tb_dmac_master_burst;
  import dmac_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 8;

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
    bit            err;
  } desc_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          m_begin = 1'b0;
  logic          desc_empty = 1'b1;
  logic          desc_pop;
  logic          desc_ack = 1'b0;
  logic          desc_err = 1'b0;
  logic [AW-1:0] desc_src = '0;
  logic [AW-1:0] desc_dst = '0;
  logic [LW-1:0] desc_len = '0;
  logic          m_req;
  logic          m_wr;
  logic          m_grant = 1'b0;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_dout;
  logic [DW-1:0] m_din = '0;
  logic          m_end;
  logic          m_err;
  logic          busy;
  logic [3:0]    state;

  dmac_master_burst dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m_begin    (m_begin),
    .desc_empty (desc_empty),
    .desc_pop   (desc_pop),
    .desc_ack   (desc_ack),
    .desc_err   (desc_err),
    .desc_src   (desc_src),
    .desc_dst   (desc_dst),
    .desc_len   (desc_len),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_grant    (m_grant),
    .m_address  (m_address),
    .m_dout     (m_dout),
    .m_din      (m_din),
    .m_end      (m_end),
    .m_err      (m_err),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk = ~clk;

  desc_t         fifo_q[$];
  logic [AW-1:0] exp_rd[$];
  wr_t           exp_wr[$];

  int n_assert = 0;
  int n_fail = 0;
  int rd_delay = 0;
  int wr_delay = 0;
  int wait_cnt = 0;
  int end_cnt = 0;
  int err_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int exp_latency = 1;
  int exp_err = 0;
  bit ack_pending = 1'b0;
  bit rd_pending = 1'b0;
  bit chk_after_rd = 1'b0;
  bit chk_after_wr = 1'b0;
  bit flush = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [AW+DW:0]   snap = '0;
  logic [DW-1:0]    salt = 32'h1357_9BDF;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a} ^ salt;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Queues one descriptor and pushes the bus traffic and cycle cost it should produce.
  task automatic applyStimulus(input desc_t d);
    logic [AW-1:0] a;
    fifo_q.push_back(d);
    exp_latency += 3;
    if (d.err) begin
      exp_err++;
    end else begin
      for (int i = 0; i < int'(d.len); i++) begin
        a = d.src + AW'(i);
        exp_rd.push_back(a);
        exp_wr.push_back('{addr: d.dst + AW'(i), data: data_of(a)});
        exp_latency += 3 + rd_delay + wr_delay;
      end
    end
  endtask

  // Pulses m_begin, waits (bounded) for m_end and checks timing, pulse counts and drained queues.
  task automatic runBlock(input string tag, input int poke);
    int cyc;
    bit seen;
    int exp_end;
    int exp_err_total;
    exp_end = end_cnt + 1;
    exp_err_total = err_cnt + exp_err;
    @(negedge clk);
    #1;
    m_begin = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      m_begin = (poke > 1 && cyc == poke);
      if (m_end === 1'b1) seen = 1'b1;
    end
    m_begin = 1'b0;
    checkOutput({tag, " m_end seen"}, 64'(seen), 64'(1));
    checkOutput({tag, " latency"}, 64'(cyc), 64'(exp_latency));
    checkOutput({tag, " busy in DONE"}, 64'(busy), 64'(1));
    repeat (3) @(negedge clk);
    #1;
    checkOutput({tag, " state idle"}, 64'(state), 64'(ST_IDLE));
    checkOutput({tag, " busy idle"}, 64'(busy), 64'(0));
    checkOutput({tag, " m_end count"}, 64'(end_cnt), 64'(exp_end));
    checkOutput({tag, " m_err count"}, 64'(err_cnt), 64'(exp_err_total));
    checkOutput({tag, " reads left"}, 64'(exp_rd.size()), 64'(0));
    checkOutput({tag, " writes left"}, 64'(exp_wr.size()), 64'(0));
    exp_latency = 1;
    exp_err = 0;
  endtask

  // Descriptor FIFO and bus slave model: acks one cycle after a pop, grants after a set delay,
  // returns read data only in the cycle after the read grant, and scores every granted access.
  always @(negedge clk) begin
    desc_t cur;
    wr_t   w;
    if (flush) begin
      fifo_q.delete();
      exp_rd.delete();
      exp_wr.delete();
      ack_pending = 1'b0;
      rd_pending = 1'b0;
      chk_after_rd = 1'b0;
      chk_after_wr = 1'b0;
      wait_cnt = 0;
    end
    desc_ack = 1'b0;
    desc_err = 1'b0;
    if (ack_pending) begin
      ack_pending = 1'b0;
      if (fifo_q.size() > 0) begin
        cur = fifo_q.pop_front();
        desc_src = cur.src;
        desc_dst = cur.dst;
        desc_len = cur.len;
        if (cur.err) desc_err = 1'b1;
        else         desc_ack = 1'b1;
      end
    end
    if (desc_pop === 1'b1) ack_pending = 1'b1;
    desc_empty = (fifo_q.size() == 0);

    if (rd_pending) begin
      m_din = data_of(rd_addr);
      rd_pending = 1'b0;
    end else begin
      m_din = ~salt ^ DW'(rd_cnt);
    end

    if (chk_after_rd) begin
      checkOutput("m_req drop after read grant", 64'(m_req), 64'(0));
      chk_after_rd = 1'b0;
    end
    if (chk_after_wr) begin
      checkOutput("m_wr drop after write grant", 64'(m_wr), 64'(0));
      chk_after_wr = 1'b0;
    end

    m_grant = 1'b0;
    if (m_req === 1'b1) begin
      if (wait_cnt == 0) snap = {m_wr, m_address, m_dout};
      else checkOutput("bus held while waiting", 64'({m_wr, m_address, m_dout}), 64'(snap));
      if (wait_cnt >= (m_wr ? wr_delay : rd_delay)) begin
        m_grant = 1'b1;
        wait_cnt = 0;
        if (m_wr === 1'b0) begin
          rd_cnt++;
          n_assert++;
          assert (exp_rd.size() > 0) else begin
            n_fail++;
            $error("[TB] FAIL unexpected read: observed addr %0h, expected no read", m_address);
          end
          if (exp_rd.size() > 0) checkOutput("read address", 64'(m_address), 64'(exp_rd.pop_front()));
          rd_addr = m_address;
          rd_pending = 1'b1;
          chk_after_rd = 1'b1;
        end else begin
          wr_cnt++;
          n_assert++;
          assert (exp_wr.size() > 0) else begin
            n_fail++;
            $error("[TB] FAIL unexpected write: observed addr %0h, expected no write", m_address);
          end
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            checkOutput("write address", 64'(m_address), 64'(w.addr));
            checkOutput("write data", 64'(m_dout), 64'(w.data));
          end
          chk_after_wr = 1'b1;
        end
      end else begin
        wait_cnt++;
      end
    end
    if (m_end === 1'b1) end_cnt++;
    if (m_err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  rd_base;
    int  wr_base;
    bit  found;
    salt = $urandom;
    #2 reset_n = 1'b0;
    #20;
    checkOutput("reset m_req", 64'(m_req), 64'(0));
    checkOutput("reset m_wr", 64'(m_wr), 64'(0));
    checkOutput("reset m_address", 64'(m_address), 64'(0));
    checkOutput("reset m_dout", 64'(m_dout), 64'(0));
    checkOutput("reset desc_pop", 64'(desc_pop), 64'(0));
    checkOutput("reset m_end", 64'(m_end), 64'(0));
    checkOutput("reset m_err", 64'(m_err), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset state", 64'(state), 64'(ST_IDLE));
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    $display("[TB] begin with empty FIFO");
    runBlock("empty", 0);

    $display("[TB] single descriptor len=3");
    applyStimulus('{src: 16'h0010, dst: 16'h0100, len: 8'd3, err: 1'b0});
    runBlock("single", 0);

    $display("[TB] two queued descriptors, m_begin poked mid-transfer");
    applyStimulus('{src: 16'h0020, dst: 16'h0120, len: 8'd1, err: 1'b0});
    applyStimulus('{src: 16'h0030, dst: 16'h0130, len: 8'd2, err: 1'b0});
    runBlock("two desc", 5);

    $display("[TB] write grant delayed 4 cycles");
    wr_delay = 4;
    applyStimulus('{src: 16'h0050, dst: 16'h0150, len: 8'd2, err: 1'b0});
    runBlock("wr delay", 0);
    wr_delay = 0;

    $display("[TB] source address wrap");
    rd_delay = 2;
    applyStimulus('{src: 16'hFFFF, dst: 16'h0200, len: 8'd2, err: 1'b0});
    runBlock("wrap", 0);
    rd_delay = 0;

    $display("[TB] zero-length descriptor then len=1");
    rd_base = rd_cnt;
    applyStimulus('{src: 16'h0058, dst: 16'h0158, len: 8'd0, err: 1'b0});
    applyStimulus('{src: 16'h0060, dst: 16'h0160, len: 8'd1, err: 1'b0});
    runBlock("len0", 0);
    checkOutput("len0 read count", 64'(rd_cnt - rd_base), 64'(1));

`ifdef DMAC_MASTER_ERR_EN
    $display("[TB] descriptor error on first of two");
    rd_base = rd_cnt;
    applyStimulus('{src: 16'h0068, dst: 16'h0168, len: 8'd2, err: 1'b1});
    applyStimulus('{src: 16'h0070, dst: 16'h0170, len: 8'd1, err: 1'b0});
    runBlock("desc err", 0);
    checkOutput("desc err read count", 64'(rd_cnt - rd_base), 64'(1));
`endif

    $display("[TB] maximum length block");
    applyStimulus('{src: 16'h1000, dst: 16'h2000, len: 8'd255, err: 1'b0});
    runBlock("max len", 0);

    $display("[TB] reset asserted during RD_CAP");
    applyStimulus('{src: 16'h0040, dst: 16'h0340, len: 8'd3, err: 1'b0});
    @(negedge clk);
    #1 m_begin = 1'b1;
    @(negedge clk);
    #1 m_begin = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (state === ST_RD_CAP) found = 1'b1;
    end
    checkOutput("reached RD_CAP", 64'(found), 64'(1));
    #2;
    reset_n = 1'b0;
    flush = 1'b1;
    #1;
    checkOutput("mid reset m_req", 64'(m_req), 64'(0));
    checkOutput("mid reset m_wr", 64'(m_wr), 64'(0));
    checkOutput("mid reset m_address", 64'(m_address), 64'(0));
    checkOutput("mid reset m_dout", 64'(m_dout), 64'(0));
    checkOutput("mid reset busy", 64'(busy), 64'(0));
    checkOutput("mid reset state", 64'(state), 64'(ST_IDLE));
    wr_base = wr_cnt;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    flush = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("no write after reset", 64'(wr_cnt - wr_base), 64'(0));
    checkOutput("idle after reset", 64'(state), 64'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
